// File: rtl/fifo_wr_packer.sv
// Write-side front end for the async FIFO: packs a byte stream little-endian into
// WIDTH-bit words, with explicit/auto flush. Optional idle auto-flush: PACKER_TIMEOUT_EN.
module fifo_wr_packer #(
  parameter int unsigned WIDTH          = 32,
  parameter logic [7:0]  PAD_BYTE       = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         wclk_i,
  input  logic                         rst_ni,
  input  logic [7:0]                   in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  input  logic                         full_i,
  output logic                         we_o,
  output logic [WIDTH-1:0]             wdata_o,
  output logic [$clog2(WIDTH/8)-1:0]   byte_cnt_o,
  output logic                         flush_busy_o
);

  localparam int BYTES = int'(WIDTH / 8);
  localparam int CW    = $clog2(BYTES);

  if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_width_check
    $error("fifo_wr_packer: WIDTH must be a multiple of 8 and at least 16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("fifo_wr_packer: TIMEOUT_CYCLES must be at least 2");
  end

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             flush_pend_q, flush_pend_d;

  logic             drain, out_free, last_lane, accept, full_word;
  logic             flush_req, flush_exec, load, tmo_hit;
  logic [CW:0]      cnt_after;
  logic [WIDTH-1:0] acc_merged, word_padded;

  // The output register frees up in the same cycle the FIFO takes its word, so a
  // new word can load on the drain edge and the stream keeps 1 byte/cycle.
  assign drain      = out_vld_q & ~full_i;
  assign out_free   = ~out_vld_q | drain;
  assign last_lane  = (cnt_q == CW'(BYTES - 1));
  assign in_ready_o = ~last_lane | out_free;
  assign accept     = in_valid_i & in_ready_o;
  assign cnt_after  = {1'b0, cnt_q} + (CW + 1)'(accept);
  assign full_word  = accept & last_lane;

  assign flush_req  = flush_i | flush_pend_q;
  assign flush_exec = flush_req & ~full_word & (cnt_after != '0) & out_free;
  assign load       = full_word | flush_exec;

  always_comb begin
    acc_merged = acc_q;
    for (int i = 0; i < BYTES; i++) begin
      if (accept && (cnt_q == CW'(i))) acc_merged[8*i +: 8] = in_data_i;
    end
  end

  // Lanes beyond the (post-accept) count are padded; for a full word none are.
  always_comb begin
    word_padded = '0;
    for (int i = 0; i < BYTES; i++) begin
      word_padded[8*i +: 8] = ((CW + 1)'(i) < cnt_after) ? acc_merged[8*i +: 8] : PAD_BYTE;
    end
  end

  // NOTE: every signal gets its default before any branch, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    cnt_d        = cnt_after[CW-1:0];
    acc_d        = acc_merged;
    out_d        = out_q;
    out_vld_d    = out_vld_q & ~drain;
    flush_pend_d = (flush_req | tmo_hit) & (cnt_after != '0);
    if (load) begin
      cnt_d        = '0;
      acc_d        = '0;
      out_d        = word_padded;
      out_vld_d    = 1'b1;
      flush_pend_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order. The data registers are reset
  // as well, so wdata_o reads 0 after reset instead of stale X.
  always_ff @(posedge wclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q;

  // The timeout raises a pending flush; the flush itself executes a cycle later.
  assign tmo_hit = (cnt_q != '0) & ~accept & (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if ((cnt_q == '0) || accept || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign we_o         = out_vld_q;
  assign wdata_o      = out_q;
  assign byte_cnt_o   = cnt_q;
  assign flush_busy_o = flush_pend_q;

  a_hold_stable : assert property (@(posedge wclk_i) disable iff (!rst_ni)
    (we_o && full_i) |=> (we_o && $stable(wdata_o)));

  a_flush_needs_data : assert property (@(posedge wclk_i) disable iff (!rst_ni)
    flush_busy_o |-> (byte_cnt_o != '0));

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench for fifo_wr_packer: a queue-based byte/word model predicts each
// FIFO write; a negedge monitor compares handshake state and every word the FIFO takes.
module tb_fifo_wr_packer;

  localparam int         WIDTH = 32;
  localparam int         BYTES = WIDTH / 8;
  localparam int         TMO   = 8;
  localparam logic [7:0] PAD   = 8'h00;
`ifdef PACKER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             full;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic [1:0]       byte_cnt;
  logic             flush_busy;

  fifo_wr_packer #(
    .WIDTH          (WIDTH),
    .PAD_BYTE       (PAD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wclk_i       (clk),
    .rst_ni       (rst_n),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .flush_i      (flush),
    .full_i       (full),
    .we_o         (we),
    .wdata_o      (wdata),
    .byte_cnt_o   (byte_cnt),
    .flush_busy_o (flush_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]       partial[$];   // bytes accepted but not yet packed
  logic [WIDTH-1:0] exp_q[$];     // words expected at the FIFO, in order
  bit               m_slot;       // a word is waiting at the FIFO port
  bit               m_pend;       // a flush has been requested, not yet done
  int               m_idle;

  always @(posedge clk or negedge rst_n) begin : model
    int               pre;
    bit               drain, rdy, acc, req, hit, ld;
    logic [WIDTH-1:0] w;
    if (!rst_n) begin
      partial.delete();
      exp_q.delete();
      m_slot = 0;
      m_pend = 0;
      m_idle = 0;
    end else begin
      pre   = partial.size();
      drain = m_slot && !full;
      rdy   = (pre < BYTES - 1) || !m_slot || drain;
      acc   = in_valid && rdy;
      if (acc) partial.push_back(in_data);
      hit = 0;
      if (TMO_EN) begin
        if (pre == 0 || acc) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TMO) begin hit = 1; m_idle = 0; end
        end
      end
      req = flush || m_pend;
      ld  = (partial.size() == BYTES) ||
            (req && partial.size() > 0 && (!m_slot || drain));
      if (ld) begin
        w = {(WIDTH / 8){PAD}};
        for (int i = 0; i < partial.size(); i++) w[8*i +: 8] = partial[i];
        exp_q.push_back(w);
        partial.delete();
        m_slot = 1;
        m_pend = 0;
      end else begin
        m_pend = (req || hit) && partial.size() > 0;
        if (drain) m_slot = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [WIDTH-1:0] w;
    if (rst_n) begin
      check("we_o", we, m_slot);
      check("byte_cnt_o", byte_cnt, partial.size());
      check("flush_busy_o", flush_busy, m_pend);
      check("in_ready_o", in_ready, (partial.size() < BYTES - 1) || !m_slot || !full);
      if (we && !full) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: wdata_o=%h with no word expected (t=%0t)", wdata, $time);
        end else begin
          w = exp_q.pop_front();
          check("wdata_o", wdata, w);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit done = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; full = 1'b0;
    #1;
    check("rst_we", we, 0);
    check("rst_wdata", wdata, 0);
    check("rst_cnt", byte_cnt, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // single word
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("w1_we", we, 1);
    check("w1_data", wdata, 32'h44332211);
    tick();
    check("w1_we_drop", we, 0);
    check("w1_cnt", byte_cnt, 0);

    // back-to-back words
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      if (i == 4) check("b2b_w0", wdata, 32'h04030201);
      if (i == 8) check("b2b_w1", wdata, 32'h08070605);
    end
    tick();

    // backpressure: word held while full, stream stalls at cnt=3
    full = 1'b1;
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    fork
      for (int i = 1; i <= 7; i++) send(8'(i));
      begin
        repeat (10) tick();
        check("bp_ready", in_ready, 0);
        check("bp_cnt", byte_cnt, 3);
        check("bp_hold", wdata, 32'hA3A2A1A0);
        full = 1'b0;
      end
    join
    pulse_flush();
    check("bp_tail", wdata, 32'h00070605);
    tick();

    // explicit flush of a partial word
    send(8'hAA); send(8'hBB);
    pulse_flush();
    check("fl_we", we, 1);
    check("fl_data", wdata, 32'h0000BBAA);
    check("fl_cnt", byte_cnt, 0);
    check("fl_busy", flush_busy, 0);

    // flush on empty accumulator is a no-op; same-cycle byte + flush
    pulse_flush();
    check("fl0_we", we, 0);
    check("fl0_busy", flush_busy, 0);
    in_valid = 1'b1; in_data = 8'hCC; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flcc_data", wdata, 32'h000000CC);
    tick();

    // flush while blocked; later bytes join the flushed word
    full = 1'b1;
    send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
    send(8'h01);
    pulse_flush();
    check("flb_busy", flush_busy, 1);
    send(8'h02);
    check("flb_cnt", byte_cnt, 2);
    full = 1'b0;
    tick();
    check("flb_data", wdata, 32'h00000201);
    check("flb_busy_clr", flush_busy, 0);
    tick();

    // idle partial word: auto-flush only with the timeout feature
    send(8'h5A);
    seen = 0;
    k = 0;
    for (int n = 1; n <= 30 && !seen; n++) begin
      tick();
      if (we) begin seen = 1; k = n; end
    end
    if (TMO_EN) begin
      check("tmo_latency", k, 9);
      check("tmo_data", wdata, 32'h0000005A);
    end else begin
      check("no_auto_flush", seen, 0);
      pulse_flush();
      check("manual_data", wdata, 32'h0000005A);
    end
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      flush    = ($urandom_range(0, 24) == 0);
      full     = ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; full = 1'b0;
    tick();
    pulse_flush();
    repeat (3) tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_partial", partial.size(), 0);

    // reset mid-word and with an undelivered word
    send(8'h01); send(8'h02);
    rst_n = 1'b0;
    #1;
    check("rstm_cnt", byte_cnt, 0);
    check("rstm_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    full = 1'b1;
    send(8'hE0); send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
    rst_n = 1'b0;
    #1;
    check("rstw_we", we, 0);
    check("rstw_wdata", wdata, 0);
    check("rstw_busy", flush_busy, 0);
    full = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rstw_no_write", we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-side front end for the async FIFO, running entirely in the write clock domain.
- Accepts a byte stream on a valid/ready handshake and packs it little-endian into WIDTH-bit words.
- Presents each word to the FIFO write port (wdata/we) and honours full backpressure.
- Supports explicit flush of a partial word, padded with PAD_BYTE, so short messages (e.g. UART/SPI bursts) are not stranded.

Parameters:
WIDTH, 32, output word width; multiple of 8, ≥16; equals the downstream FIFO WIDTH.
PAD_BYTE, 8'h00, fill value for unused byte lanes of a flushed partial word.
TIMEOUT_CYCLES, 64, idle cycles before auto-flush; used only when PACKER_TIMEOUT_EN is defined; ≥2.

Ports:
wclk_i  in  1  write-domain clock; all logic on posedge.
rst_ni  in  1  asynchronous active-low reset.
in_data_i  in  8  incoming byte.
in_valid_i  in  1  in_data_i valid.
in_ready_o  out  1  packer can accept a byte this cycle.
flush_i  in  1  single-cycle pulse requesting a partial-word flush.
full_i  in  1  FIFO full flag (write domain).
we_o  out  1  FIFO write enable; equals the output-register-valid flag.
wdata_o  out  WIDTH  FIFO write data; stable while we_o=1 and full_i=1.
byte_cnt_o  out  $clog2(WIDTH/8)  bytes currently held in the accumulator.
flush_busy_o  out  1  a flush request is pending.

Behaviour:
- BYTES = WIDTH/8. Accumulator acc holds 0..BYTES-1 bytes; cnt is its count.
- Output register: out_q (WIDTH bits), out_vld. we_o = out_vld; wdata_o = out_q.
- Reset (async, rst_ni=0): cnt=0, acc=0, out_vld=0, out_q=0, flush_pend=0, timeout counter=0.
  - All outputs are 0 during and after reset until stimulus arrives.
  - Exception: in_ready_o=1, since it is combinational from the empty state.
- drain = out_vld & ~full_i; the FIFO accepts the word at this edge. out_free = ~out_vld | drain.
- in_ready_o = (cnt < BYTES-1) | out_free. It is combinational with no dependence on in_valid_i.
- Byte accept (in_valid_i & in_ready_o): byte goes to lane cnt, i.e. bits [8*cnt+7:8*cnt].
  - If cnt < BYTES-1: cnt increments.
  - If cnt == BYTES-1: the completed word {byte, acc} loads into out_q and out_vld=1 the next cycle, and cnt becomes 0.
  - Latency from final byte accept to we_o=1 is 1 cycle.
- Back-to-back full words are supported at 1 byte/cycle, provided the FIFO drains.
  - Drain and load in the same cycle are legal: out_vld stays 1 and out_q takes the new word.
- Flush:
  - flush_i=1 sets flush_pend. flush_i with cnt=0, no byte accepted that cycle, and no pending flush is a no-op; flush_pend is not set.
  - Flush executes on the first cycle with flush_pend (or flush_i) set, cnt > 0 (counting a byte accepted the same cycle), and out_free.
  - On execute: out_q = acc with the same-cycle byte merged and lanes ≥ new count set to PAD_BYTE; out_vld=1; cnt=0; flush_pend=0.
  - If the same-cycle byte completes a full word, it is a normal full-word load. flush_pend then clears because the accumulator is empty.
  - While flush_pend=1 and the output is blocked, further bytes are still accepted while cnt < BYTES-1. They join the word that is flushed.
  - flush_busy_o = flush_pend.
- Reset mid-operation: the partial accumulator and any undelivered out_q are discarded; no write is issued.
- Overflow is not possible; backpressure propagates through in_ready_o only.

Optional Feature:
Macro PACKER_TIMEOUT_EN.
- Defined: a counter increments each cycle while cnt > 0 and no byte is accepted, and clears on accept or when cnt=0. On reaching TIMEOUT_CYCLES-1 it sets flush_pend exactly as flush_i would, then clears. It restarts after the flush.
- Undefined: no counter logic; partial words leave only via flush_i.

Test Plan:
- Reset, then 4 bytes 11,22,33,44 on consecutive cycles with full_i=0 → one cycle after the 4th accept, we_o=1 and wdata_o=32'h44332211 for exactly 1 cycle; byte_cnt_o returns to 0.
- 8 back-to-back bytes 01..08 → we_o pulses with 32'h04030201, then 32'h08070605; in_ready_o stays 1 throughout.
- full_i=1 held with a word pending, stream 01..07 → in_ready_o drops after 3 bytes are accumulated (cnt=3) and wdata_o holds steady. Release full_i → the held word writes, the next word completes, and stalled bytes resume.
- Bytes AA,BB then flush_i pulse, full_i=0 → we_o=1 with wdata_o=32'h0000BBAA (PAD_BYTE=00); byte_cnt_o=0; flush_busy_o low after execute.
- flush_i with cnt=0 → no write and flush_busy_o stays 0. Byte CC accepted in the same cycle as flush_i → wdata_o=32'h000000CC.
- Macro defined, TIMEOUT_CYCLES=8: one byte 5A, then idle → we_o rises with 32'h0000005A about 9 cycles after the accept. Assert rst_ni low mid-word → no write, and all state clears immediately.
